// File: rtl/serial_compare_pkg.sv
// Shared types for the MSB-first serial comparator front end.
// Holds the feeder FSM state encoding and the bit-counter width helper.
package serial_compare_pkg;

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_clear = 2'd1,
        st_shift = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/msb_first_shift_reg.sv
// W-bit parallel-load shift register that shifts left, zero-fills and
// exposes its MSB as the serial output.
import serial_compare_pkg::*;

module msb_first_shift_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);

    logic [W-1:0] r_data;

    // Load wins over shift so a back-to-back word replaces the drained one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {r_data[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_data[W-1];

endmodule

// File: rtl/serial_comparator_msb_first_feeder.sv
// Frames word pairs for the MSB-first serial comparator: clear pulse, W serial
// bits, then a registered one-cycle capture of the comparator flags.
module serial_comparator_msb_first_feeder
    import serial_compare_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         cmp_rst,
    output logic         a,
    output logic         b,
    output logic         bit_valid,
    output logic         last_bit,
    input  logic         cmp_lt,
    input  logic         cmp_eq,
    input  logic         cmp_gt,
    output logic         res_valid,
    output logic         res_lt,
    output logic         res_eq,
    output logic         res_gt
);

    localparam int            CW      = cnt_w(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_cmp_rst;
    logic          r_bit_valid;
    logic          r_res_valid;
    logic          r_res_lt;
    logic          r_res_eq;
    logic          r_res_gt;

    logic w_cnt_zero;
    logic w_shift;
    logic w_last;
    logic w_ready;
    logic w_hs;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_shift    = (r_state == st_shift);
    assign w_last     = w_shift & w_cnt_zero;
    // Ready is a pure state/counter decode so no in_valid path reaches it.
    assign w_ready    = (r_state == st_idle) | w_last;
    assign w_hs       = in_valid & w_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= st_idle;
            r_cnt       <= '0;
            r_cmp_rst   <= 1'b1;
            r_bit_valid <= 1'b0;
        end else begin
            case (r_state)
                st_idle: begin
                    if (w_hs) begin
                        r_state <= st_clear;
                        r_cnt   <= CNT_TOP;
                    end
                end
                st_clear: begin
                    r_state     <= st_shift;
                    r_cmp_rst   <= 1'b0;
                    r_bit_valid <= 1'b1;
                end
                st_shift: begin
                    if (w_cnt_zero) begin
                        r_cmp_rst   <= 1'b1;
                        r_bit_valid <= 1'b0;
                        if (w_hs) begin
                            r_state <= st_clear;
                            r_cnt   <= CNT_TOP;
                        end else begin
                            r_state <= st_idle;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state     <= st_idle;
                    r_cmp_rst   <= 1'b1;
                    r_bit_valid <= 1'b0;
                end
            endcase
        end
    end

    // The comparator flags already include the LSB during the last_bit cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_valid <= 1'b0;
            r_res_lt    <= 1'b0;
            r_res_eq    <= 1'b0;
            r_res_gt    <= 1'b0;
        end else begin
            r_res_valid <= w_last;
            if (w_last) begin
                r_res_lt <= cmp_lt;
                r_res_eq <= cmp_eq;
                r_res_gt <= cmp_gt;
            end
        end
    end

    msb_first_shift_reg #(.W(W)) u_sr_a (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_hs),
        .i_shift (w_shift),
        .i_data  (in_a),
        .o_msb   (a)
    );

    msb_first_shift_reg #(.W(W)) u_sr_b (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_hs),
        .i_shift (w_shift),
        .i_data  (in_b),
        .o_msb   (b)
    );

    assign in_ready  = w_ready;
    assign last_bit  = w_last;
    assign cmp_rst   = r_cmp_rst;
    assign bit_valid = r_bit_valid;
    assign res_valid = r_res_valid;
    assign res_lt    = r_res_lt;
    assign res_eq    = r_res_eq;
    assign res_gt    = r_res_gt;

endmodule

// File: doc/serial_comparator_msb_first_feeder.md
# serial_comparator_msb_first_feeder

Upstream framing stage for the MSB-first serial comparator. It accepts word pairs `{in_a, in_b}` over a valid/ready handshake and shifts them out one bit per cycle, most significant bit first, on `a`/`b`. Before each word it emits a one-cycle `cmp_rst` pulse so the comparator starts every word in its "equal" state. It then captures the comparator's three flags on the last bit and presents them as a registered, single-cycle result.

## Interface
- `W`, 8: word width in bits; legal range W >= 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserting low clears all state immediately, deassertion is synchronous to `clk`.
- `in_valid`  in  1  word pair offered.
- `in_ready`  out  1  feeder can accept a word pair this cycle.
- `in_a`  in  W  operand A, unsigned.
- `in_b`  in  W  operand B, unsigned.
- `cmp_rst`  out  1  synchronous active-high reset to the comparator.
- `a`  out  1  serial bit of A, MSB first.
- `b`  out  1  serial bit of B, MSB first.
- `bit_valid`  out  1  `a`/`b` carry a real bit this cycle.
- `last_bit`  out  1  current bit is bit 0 (LSB).
- `cmp_lt`  in  1  comparator `a_less_b`.
- `cmp_eq`  in  1  comparator `a_eq_b`.
- `cmp_gt`  in  1  comparator `a_greater_b`.
- `res_valid`  out  1  one-cycle pulse; result fields valid.
- `res_lt`  out  1  captured result flag.
- `res_eq`  out  1  captured result flag.
- `res_gt`  out  1  captured result flag.

## Operation
- The FSM has three states:
  - IDLE: `in_ready`=1 and `cmp_rst`=1. A handshake (`in_valid & in_ready`) moves to CLEAR.
  - CLEAR: `cmp_rst`=1 and `bit_valid`=0. Always moves to SHIFT.
  - SHIFT: `bit_valid`=1 and `cmp_rst`=0. The bit counter counts W-1 down to 0.
- Leaving SHIFT, which happens only on the cycle with counter == 0:
  - if a handshake occurs, go to CLEAR;
  - otherwise go to IDLE.
- Handshake and loading:
  - The handshake loads `in_a` and `in_b` into two W-bit shift registers and sets the counter to W-1.
  - `in_ready`=1 in IDLE and on the last SHIFT cycle, which allows back-to-back words. It is 0 in CLEAR and in every other SHIFT cycle.
  - `in_ready` is decoded from state and counter only. It never depends on `in_valid`.
- Serial data:
  - `a` and `b` are the MSBs of the shift registers.
  - Each SHIFT cycle shifts both registers left by one and fills a 0.
  - `last_bit` = (state == SHIFT) & (counter == 0).
  - Outside SHIFT, `a` and `b` are don't-care, and the bench must not check them.
- Result capture:
  - On the edge that ends the `last_bit` cycle, `cmp_lt`/`cmp_eq`/`cmp_gt` are registered into `res_*` and `res_valid` is set for exactly one cycle.
  - `res_*` hold their value until the next capture.
  - There is no backpressure on the result.
- Reset mid-word:
  - The word is aborted, with no `res_valid`.
  - The FSM goes to IDLE, the counter and shift registers are cleared, and `res_*` is cleared.
- Reset values of the outputs: `in_ready`=1, `cmp_rst`=1, `bit_valid`=0, `last_bit`=0, `a`=0, `b`=0, `res_valid`=0, `res_lt`=0, `res_eq`=0, `res_gt`=0.

## Timing
- A handshake at edge T gives:
  - cycle T+1: CLEAR;
  - cycles T+2 .. T+W+1: bits W-1 .. 0;
  - cycle T+W+1: `last_bit`;
  - cycle T+W+2: `res_valid`.
- Throughput is one word per W+1 cycles with continuous `in_valid`.
- `cmp_rst`, sampled by the comparator at the end of CLEAR, guarantees the comparator is in "equal" during the MSB cycle.
- `res_valid` for word N and the CLEAR cycle of word N+1 coincide.
- `cmp_rst`, `bit_valid`, `a`, `b` and `res_*` come straight from registers. `last_bit` and `in_ready` are a decode of registers only, with no input-to-output combinational path.

## Structure
- Package `serial_compare_pkg` holds:
  - the state enum (`st_idle`, `st_clear`, `st_shift`);
  - the function `cnt_w(W) = $clog2(W)`.
- Sub-module `msb_first_shift_reg #(W)` provides load/shift and an MSB output. It is instantiated twice, once for A and once for B.
- FSM, counter and result capture live in the top module.

## Test plan
- Reset with `rst`=0, then release. For 3 idle cycles check `in_ready`=1, `cmp_rst`=1, `bit_valid`=0 and `res_valid`=0.
- W=8, `in_a`=8'hA5, `in_b`=8'hA4:
  - `a` reads 1,0,1,0,0,1,0,1 at T+2..T+9;
  - `b` reads 1,0,1,0,0,1,0,0 at T+2..T+9;
  - `last_bit` asserts at T+9;
  - `res_gt`=1 with `res_valid` at T+10, using the golden comparator in the bench.
- Back-to-back words with `in_valid` held high: (8'h10, 8'h80) then (8'h3C, 8'h3C):
  - `in_ready` is high only at T and T+9;
  - the second CLEAR is at T+10;
  - the results are lt then eq, spaced 9 cycles apart.
- Stall: `in_valid` is dropped for 5 cycles after word 1. The FSM returns to IDLE, and `cmp_rst` stays 1 throughout.
- Reset mid-word: assert `rst` at the 4th bit of (8'hFF, 8'h00). Outputs return to their reset values immediately, and no `res_valid` appears.
- Random sweep with W=4 over all 256 operand pairs, with random `in_valid` gaps. Every `res_*` must match a reference compare.
